g_seq_shift_trunc: RTL and testbench



---
 rtl/g_seq_shift_trunc_pkg.sv | 34 +++
 rtl/g_seq_shift_trunc_if.sv | 25 ++
 rtl/g_seq_shift_trunc_step.sv | 30 +++
 rtl/g_seq_shift_trunc.sv | 117 +++++++++++
 tb/tb_g_seq_shift_trunc.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/g_seq_shift_trunc_pkg.sv
// Shared constants, opcodes and FSM states for the multi-cycle shift/truncate unit.
// SHIFT_SRA_EN selects whether opcode 010 is an arithmetic shift or a passthrough.
package g_shift_pkg;

  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  localparam logic [2:0] OP_SLL    = 3'b000;
  localparam logic [2:0] OP_SRL    = 3'b001;
  localparam logic [2:0] OP_SRA    = 3'b010;
  localparam logic [2:0] OP_LTRUNC = 3'b011;
  localparam logic [2:0] OP_HTRUNC = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    PHASE1,
    PHASE2,
    DONE
  } state_t;

  function automatic logic is_trunc(input logic [2:0] op);
    return (op == OP_LTRUNC) || (op == OP_HTRUNC);
  endfunction

  // Opcodes that complete without any shift steps regardless of the amount.
  function automatic logic is_passthrough(input logic [2:0] op);
`ifdef SHIFT_SRA_EN
    return op > OP_HTRUNC;
`else
    return (op > OP_HTRUNC) || (op == OP_SRA);
`endif
  endfunction

endpackage

// File: rtl/g_seq_shift_trunc_if.sv
// Request/result handshake bundle between a requester and the shift/truncate unit.
interface g_seq_shift_trunc_if;
  import g_shift_pkg::*;

  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] In1;
  logic [AMT_W-1:0] In2;
  logic [2:0]       Op;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] Out;
  logic             Busy;

  modport master (
    output In_valid, In1, In2, Op, Out_ready,
    input  In_ready, Out_valid, Out, Busy
  );

  modport slave (
    input  In_valid, In1, In2, Op, Out_ready,
    output In_ready, Out_valid, Out, Busy
  );

endinterface

// File: rtl/g_seq_shift_trunc_step.sv
// One shift step of 0..STEP bits, left or right, with zero or sign fill.
module G_ShiftStep
  import g_shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] result
);

  // Only amounts up to STEP are decoded, so this stays a small mux rather than a barrel shifter.
  always_comb begin
    result = data;
    for (int i = 1; i <= STEP; i++) begin
      if (amt == AMT_W'(i)) begin
        if (left) begin
          result = data << i;
        end else if (arith) begin
          result = $unsigned($signed(data) >>> i);
        end else begin
          result = data >> i;
        end
      end
    end
  end

endmodule

// File: rtl/g_seq_shift_trunc.sv
// Iterative shift/truncate unit: STEP bits per cycle, two opposite-direction phases for truncation.
// Define SHIFT_SRA_EN to enable the arithmetic right shift on opcode 010.
module g_seq_shift_trunc
  import g_shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input logic           clk,
  input logic           rst_n,
  g_seq_shift_trunc_if.slave bus
);

  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] out_q;
  logic [AMT_W-1:0] remain;
  logic [AMT_W-1:0] amt_q;
  logic [AMT_W-1:0] step_amt;
  logic [2:0]       op_q;
  logic             left;
  logic             arith;
  logic             last_step;
  logic             zero_steps;
  logic             in_ready;
  logic             out_valid;
  logic             busy;

  assign step_amt   = (remain < STEP_AMT) ? remain : STEP_AMT;
  assign last_step  = (remain <= STEP_AMT);
  assign zero_steps = (bus.In2 == '0) || is_passthrough(bus.Op);

  // Truncation runs its second phase in the reverse direction of the first.
  assign left = (state == PHASE2) ? (op_q == OP_HTRUNC)
                                  : ((op_q == OP_SLL) || (op_q == OP_LTRUNC));
`ifdef SHIFT_SRA_EN
  assign arith = (op_q == OP_SRA);
`else
  assign arith = 1'b0;
`endif

  G_ShiftStep #(.STEP(STEP)) u_step (
    .data   (work),
    .amt    (step_amt),
    .left   (left),
    .arith  (arith),
    .result (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.In_valid) state_nxt = zero_steps ? DONE : PHASE1;
      PHASE1:  if (last_step) state_nxt = is_trunc(op_q) ? PHASE2 : DONE;
      PHASE2:  if (last_step) state_nxt = DONE;
      DONE:    if (bus.Out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == PHASE1) || (state == PHASE2);
  end

  // The result register only changes on entry to DONE, so it never shows partial work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work   <= '0;
      remain <= '0;
      amt_q  <= '0;
      op_q   <= '0;
      out_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.In_valid) begin
            work   <= bus.In1;
            remain <= bus.In2;
            amt_q  <= bus.In2;
            op_q   <= bus.Op;
          end
        end
        PHASE1, PHASE2: begin
          work <= shifted;
          if (last_step && (state == PHASE1) && is_trunc(op_q)) begin
            remain <= amt_q;
          end else begin
            remain <= remain - step_amt;
          end
        end
        default: ;
      endcase
      if ((state != DONE) && (state_nxt == DONE)) begin
        out_q <= (state == IDLE) ? bus.In1 : shifted;
      end
    end
  end

  assign bus.In_ready  = in_ready;
  assign bus.Out_valid = out_valid;
  assign bus.Busy      = busy;
  assign bus.Out       = out_q;

endmodule

// File: tb/tb_g_seq_shift_trunc.sv
// Randomised self-checking bench for g_seq_shift_trunc, running STEP=1 and STEP=4 instances side by side.
// Honours SHIFT_SRA_EN in its reference model.
module tb_g_seq_shift_trunc;
  import g_shift_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [31:0] prev1;
  logic [31:0] prev4;

  always #5 clk = ~clk;

  g_seq_shift_trunc_if bus1();
  g_seq_shift_trunc_if bus4();

  g_seq_shift_trunc #(.STEP(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  g_seq_shift_trunc #(.STEP(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  function automatic logic [31:0] expectResult(input logic [31:0] a, input logic [4:0] n,
                                               input logic [2:0] op);
    logic [31:0] t;
    case (op)
      3'b000: return a << n;
      3'b001: return a >> n;
`ifdef SHIFT_SRA_EN
      3'b010: return $unsigned($signed(a) >>> n);
`endif
      3'b011: begin t = a << n; return t >> n; end
      3'b100: begin t = a >> n; return t << n; end
      default: return a;
    endcase
  endfunction

  function automatic int expectSteps(input logic [4:0] n, input logic [2:0] op, input int step);
    int c;
    c = (int'(n) + step - 1) / step;
    case (op)
      3'b000, 3'b001: return c;
`ifdef SHIFT_SRA_EN
      3'b010: return c;
`endif
      3'b011, 3'b100: return 2 * c;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic driveRequest(input logic v, input logic [31:0] a, input logic [4:0] n,
                              input logic [2:0] op);
    bus1.In_valid = v; bus1.In1 = a; bus1.In2 = n; bus1.Op = op;
    bus4.In_valid = v; bus4.In1 = a; bus4.In2 = n; bus4.Op = op;
  endtask

  task automatic checkIdle(input string tag, input logic [31:0] expOut);
    checkOutput({tag, " out1"}, bus1.Out, expOut);
    checkOutput({tag, " out4"}, bus4.Out, expOut);
    checkOutput({tag, " valid1"}, 32'(bus1.Out_valid), 32'd0);
    checkOutput({tag, " valid4"}, 32'(bus4.Out_valid), 32'd0);
    checkOutput({tag, " busy1"}, 32'(bus1.Busy), 32'd0);
    checkOutput({tag, " busy4"}, 32'(bus4.Busy), 32'd0);
    checkOutput({tag, " ready1"}, 32'(bus1.In_ready), 32'd1);
    checkOutput({tag, " ready4"}, 32'(bus4.In_ready), 32'd1);
  endtask

  // Called at a negedge with both units idle; leaves both idle at a negedge.
  task automatic applyStimulus(input logic [31:0] a, input logic [4:0] n, input logic [2:0] op,
                               input int hold);
    logic [31:0] expRes;
    logic [31:0] res1;
    logic [31:0] res4;
    int s1, s4, lat1, lat4, busy1, busy4;
    bit done1, done4;
    expRes = expectResult(a, n, op);
    s1 = expectSteps(n, op, 1);
    s4 = expectSteps(n, op, 4);
    lat1 = -1; lat4 = -1; busy1 = 0; busy4 = 0; done1 = 0; done4 = 0;
    res1 = '0; res4 = '0;
    checkOutput("ready before accept1", 32'(bus1.In_ready), 32'd1);
    checkOutput("ready before accept4", 32'(bus4.In_ready), 32'd1);
    driveRequest(1'b1, a, n, op);
    @(posedge clk);
    @(negedge clk);
    driveRequest(1'b0, $urandom, 5'($urandom), 3'($urandom));
    for (int c = 0; c < 80; c++) begin
      if (!done1) begin
        if (bus1.Out_valid) begin
          done1 = 1; lat1 = c; res1 = bus1.Out;
        end else begin
          if (bus1.Busy) busy1++;
          checkOutput("out held while busy1", bus1.Out, prev1);
        end
      end
      if (!done4) begin
        if (bus4.Out_valid) begin
          done4 = 1; lat4 = c; res4 = bus4.Out;
        end else begin
          if (bus4.Busy) busy4++;
          checkOutput("out held while busy4", bus4.Out, prev4);
        end
      end
      if (done1 && done4) break;
      @(negedge clk);
    end
    checkOutput("completed1", 32'(done1), 32'd1);
    checkOutput("completed4", 32'(done4), 32'd1);
    checkOutput("result1", res1, expRes);
    checkOutput("result4", res4, expRes);
    checkOutput("latency1", 32'(lat1), 32'(s1));
    checkOutput("latency4", 32'(lat4), 32'(s4));
    checkOutput("busy cycles1", 32'(busy1), 32'(s1));
    checkOutput("busy cycles4", 32'(busy4), 32'(s4));
    if (!(done1 && done4)) begin
      $display("[TB] FAIL timeout: op %0d n %0d did not complete", op, n);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] aborting after timeout");
    end
    // Backpressure: a competing request must be ignored while the result waits.
    for (int h = 0; h < hold; h++) begin
      driveRequest(1'b1, $urandom, 5'($urandom), 3'($urandom));
      @(negedge clk);
      checkOutput("bp valid1", 32'(bus1.Out_valid), 32'd1);
      checkOutput("bp valid4", 32'(bus4.Out_valid), 32'd1);
      checkOutput("bp out1", bus1.Out, expRes);
      checkOutput("bp out4", bus4.Out, expRes);
      checkOutput("bp ready1", 32'(bus1.In_ready), 32'd0);
      checkOutput("bp ready4", 32'(bus4.In_ready), 32'd0);
      checkOutput("bp busy1", 32'(bus1.Busy), 32'd0);
      checkOutput("bp busy4", 32'(bus4.Busy), 32'd0);
    end
    driveRequest(1'b0, $urandom, 5'($urandom), 3'($urandom));
    bus1.Out_ready = 1'b1;
    bus4.Out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.Out_ready = 1'b0;
    bus4.Out_ready = 1'b0;
    checkIdle("after handshake", expRes);
    prev1 = expRes;
    prev4 = expRes;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus1.Out_ready = 1'b0;
    bus4.Out_ready = 1'b0;
    driveRequest(1'b0, '0, '0, '0);
    prev1 = '0;
    prev4 = '0;
    repeat (2) @(negedge clk);
    checkIdle("in reset", 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("after reset", 32'h0);

    applyStimulus(32'hFFFF_FFFF, 5'd8, OP_LTRUNC, 0);
    applyStimulus(32'h1234_5678, 5'd12, OP_HTRUNC, 0);
    applyStimulus(32'h8000_0000, 5'd4, OP_SRA, 0);
    applyStimulus(32'h0000_0001, 5'd5, OP_SLL, 0);
    applyStimulus(32'hCAFE_F00D, 5'd0, OP_SLL, 0);
    applyStimulus(32'hF0F0_1234, 5'd9, OP_SRL, 3);
    applyStimulus(32'h0BAD_BEEF, 5'd17, 3'b110, 1);
    applyStimulus(32'h8765_4321, 5'd31, OP_LTRUNC, 0);

    // Abort an operation in flight with an asynchronous reset.
    driveRequest(1'b1, 32'hDEAD_BEEF, 5'd20, OP_SLL);
    @(posedge clk);
    @(negedge clk);
    driveRequest(1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    checkOutput("busy before abort1", 32'(bus1.Busy), 32'd1);
    checkOutput("busy before abort4", 32'(bus4.Busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkIdle("async reset", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    prev1 = '0;
    prev4 = '0;
    applyStimulus(32'h0000_00F0, 5'd3, OP_SRL, 0);

    for (int t = 0; t < 40; t++) begin
      applyStimulus($urandom, 5'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
